// File: rtl/clkdiv_scheduler.sv
// clkdiv_scheduler: run-time sequencer for a bank of NCH clock dividers (channel 0 = master).
// Handles start / arm-on-trigger / burst / stop, shadowed ratio commits on master
// boundaries, and phase-aligned restarts.
// Optional build macro CLKDIV_SCHED_PHASE_EN adds a per-channel phase_off input.
module clkdiv_scheduler #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned BURST_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 exttrig,
   input  logic                 trig_mode,
   input  logic [NCH*CNT_W-1:0] div_ratio,
   input  logic                 cfg_load,
   input  logic [BURST_W-1:0]   burst_len,
`ifdef CLKDIV_SCHED_PHASE_EN
   input  logic [NCH*CNT_W-1:0] phase_off,
`endif
   output logic                 cfg_ack,
   output logic [NCH-1:0]       pulse_out,
   output logic                 busy,
   output logic [1:0]           state,
   output logic [BURST_W-1:0]   period_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, STOP = 2'd3} state_t;

   state_t             state_q, state_d;
   logic               trig_q;
   logic               pending_q, pending_d;
   logic               ack_d;
   logic [BURST_W-1:0] pcnt_d;
   logic [NCH-1:0]     pulse_d;
   logic [CNT_W-1:0]   shadow_q [NCH];
   logic [CNT_W-1:0]   shadow_d [NCH];
   logic [CNT_W-1:0]   active_q [NCH];
   logic [CNT_W-1:0]   active_d [NCH];
   logic [CNT_W-1:0]   cnt_q    [NCH];
   logic [CNT_W-1:0]   cnt_d    [NCH];
   logic [CNT_W-1:0]   dly_q    [NCH];
   logic [CNT_W-1:0]   dly_d    [NCH];
   logic [CNT_W-1:0]   load_val [NCH];
   logic [CNT_W-1:0]   off_val  [NCH];
   logic [NCH-1:0]     tick;
   logic               fall0;
   logic               trig_rise;

   // Per-channel decode: clamped incoming ratio, phase offset, half-period terminal count
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign load_val[g] = (div_ratio[g*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                               : div_ratio[g*CNT_W +: CNT_W];
`ifdef CLKDIV_SCHED_PHASE_EN
      assign off_val[g]  = phase_off[g*CNT_W +: CNT_W];
`else
      assign off_val[g]  = '0;
`endif
      assign tick[g]     = (dly_q[g] == '0) && (cnt_q[g] == active_q[g] - CNT_W'(1));
   end

   assign fall0     = tick[0] & pulse_out[0];
   assign trig_rise = exttrig & ~trig_q;
   assign state     = state_q;

   // Next-state, channel counters and config commit
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      ack_d     = 1'b0;
      pcnt_d    = period_cnt;
      pulse_d   = pulse_out;
      shadow_d  = shadow_q;
      active_d  = active_q;
      cnt_d     = cnt_q;
      dly_d     = dly_q;

      case (state_q)
         IDLE: begin
            pulse_d = '0;
            for (int i = 0; i < NCH; i++) begin
               cnt_d[i] = '0;
               dly_d[i] = '0;
            end
            if (start && !stop) begin
               pcnt_d = '0;
               if (trig_mode) begin
                  state_d = ARMED;
               end else begin
                  state_d = RUN;
                  dly_d   = off_val;
               end
            end
         end
         ARMED: begin
            pulse_d = '0;
            for (int i = 0; i < NCH; i++) begin
               cnt_d[i] = '0;
               dly_d[i] = '0;
            end
            if (stop) begin
               state_d = IDLE;
            end else if (trig_rise) begin
               state_d = RUN;
               dly_d   = off_val;
            end
         end
         RUN: begin
            for (int i = 0; i < NCH; i++) begin
               if (dly_q[i] != '0) begin
                  dly_d[i] = dly_q[i] - CNT_W'(1);
               end else if (tick[i]) begin
                  cnt_d[i]   = '0;
                  pulse_d[i] = ~pulse_out[i];
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            if (fall0) begin
               if (period_cnt != '1) pcnt_d = period_cnt + BURST_W'(1);
               // Pending ratios take effect here and every channel restarts in phase
               if (pending_q) begin
                  active_d  = shadow_q;
                  pulse_d   = '0;
                  dly_d     = off_val;
                  ack_d     = 1'b1;
                  pending_d = 1'b0;
                  for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
               end
               if ((burst_len != '0) && (pcnt_d >= burst_len)) state_d = STOP;
            end
            if (stop) state_d = STOP;
         end
         STOP: begin
            // High channels finish their half-period; low channels stay frozen
            for (int i = 0; i < NCH; i++) begin
               if (pulse_out[i]) begin
                  if (tick[i]) begin
                     cnt_d[i]   = '0;
                     pulse_d[i] = 1'b0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
            end
            if (pulse_out == '0) begin
               state_d = IDLE;
               for (int i = 0; i < NCH; i++) begin
                  cnt_d[i] = '0;
                  dly_d[i] = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outside RUN a load (or a leftover pending load) commits immediately
      if ((state_q != RUN) && (cfg_load || pending_q)) begin
         ack_d     = 1'b1;
         pending_d = 1'b0;
         for (int i = 0; i < NCH; i++) begin
            active_d[i] = cfg_load ? load_val[i] : shadow_q[i];
            cnt_d[i]    = '0;
         end
      end
      if (cfg_load) begin
         shadow_d = load_val;
         if (state_q == RUN) pending_d = 1'b1;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         trig_q     <= 1'b0;
         pending_q  <= 1'b0;
         cfg_ack    <= 1'b0;
         busy       <= 1'b0;
         period_cnt <= '0;
         pulse_out  <= '0;
         for (int i = 0; i < NCH; i++) begin
            shadow_q[i] <= CNT_W'(1);
            active_q[i] <= CNT_W'(1);
            cnt_q[i]    <= '0;
            dly_q[i]    <= '0;
         end
      end else begin
         state_q    <= state_d;
         trig_q     <= exttrig;
         pending_q  <= pending_d;
         cfg_ack    <= ack_d;
         busy       <= (state_d != IDLE);
         period_cnt <= pcnt_d;
         pulse_out  <= pulse_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         cnt_q      <= cnt_d;
         dly_q      <= dly_d;
      end
   end

endmodule

// File: tb/tb_clkdiv_scheduler.sv
// tb_clkdiv_scheduler: epoch-based reference model compared every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_clkdiv_scheduler;

   localparam int unsigned NCH     = 4;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned BURST_W = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 stop;
   logic                 exttrig;
   logic                 trig_mode;
   logic [NCH*CNT_W-1:0] div_ratio;
   logic                 cfg_load;
   logic [BURST_W-1:0]   burst_len;
   logic                 cfg_ack;
   logic [NCH-1:0]       pulse_out;
   logic                 busy;
   logic [1:0]           state;
   logic [BURST_W-1:0]   period_cnt;
`ifdef CLKDIV_SCHED_PHASE_EN
   logic [NCH*CNT_W-1:0] phase_off = '0;
`endif

   int errors = 0;
   int checks = 0;

   clkdiv_scheduler #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .exttrig    (exttrig),
      .trig_mode  (trig_mode),
      .div_ratio  (div_ratio),
      .cfg_load   (cfg_load),
      .burst_len  (burst_len),
`ifdef CLKDIV_SCHED_PHASE_EN
      .phase_off  (phase_off),
`endif
      .cfg_ack    (cfg_ack),
      .pulse_out  (pulse_out),
      .busy       (busy),
      .state      (state),
      .period_cnt (period_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Running channels follow pulse(t) = floor((t-E)/r) odd, with E the cycle the run
   // (or the latest commit) began. STOP keeps a channel high until its scheduled fall F.
   int              cyc = 0;
   bit              m_valid = 1'b0;
   int              m_state, m_E, m_pcnt;
   int              m_r  [NCH];
   int              m_sh [NCH];
   int              m_F  [NCH];
   bit              m_pend, m_ack, m_prev;
   bit [NCH-1:0]    m_pulse;

   function automatic bit wave(input int i, input int t);
      int d;
      d = t - m_E;
      if (d < 0) return 1'b0;
      return ((d / m_r[i]) % 2) == 1;
   endfunction

   always @(posedge clk) begin : model
      int           k, ns;
      int           lr [NCH];
      bit [NCH-1:0] np;
      bit           bnd, ack;
      cyc++;
      k = cyc;
      if (!reset) begin
         m_valid = 1'b1;
         m_state = 0; m_E = 0; m_pcnt = 0;
         m_pend = 0; m_ack = 0; m_prev = 0; m_pulse = '0;
         for (int i = 0; i < NCH; i++) begin
            m_r[i] = 1; m_sh[i] = 1; m_F[i] = 0;
         end
      end else if (m_valid) begin
         ns  = m_state;
         ack = 1'b0;
         np  = '0;
         for (int i = 0; i < NCH; i++) begin
            lr[i] = int'(div_ratio[i*CNT_W +: CNT_W]);
            if (lr[i] == 0) lr[i] = 1;
         end
         case (m_state)
            0: if (start && !stop) begin
                  m_pcnt = 0;
                  if (trig_mode) ns = 1;
                  else begin ns = 2; m_E = k; end
               end
            1: if (stop) ns = 0;
               else if (exttrig && !m_prev) begin ns = 2; m_E = k; end
            2: begin
               bnd = wave(0, k - 1) && !wave(0, k);
               if (bnd && m_pcnt < 65535) m_pcnt++;
               if (bnd && m_pend) begin
                  m_r = m_sh; m_E = k; ack = 1'b1; m_pend = 1'b0;
               end
               for (int i = 0; i < NCH; i++) np[i] = wave(i, k);
               if (stop || (bnd && burst_len != 0 && m_pcnt >= int'(burst_len))) begin
                  ns = 3;
                  for (int i = 0; i < NCH; i++)
                     if (np[i]) m_F[i] = m_E + ((k - m_E) / m_r[i] + 1) * m_r[i];
               end
            end
            default: begin
               for (int i = 0; i < NCH; i++) np[i] = m_pulse[i] && (k < m_F[i]);
               if (m_pulse == '0) ns = 0;
            end
         endcase
         if (m_state != 2 && (cfg_load || m_pend)) begin
            for (int i = 0; i < NCH; i++) m_r[i] = cfg_load ? lr[i] : m_sh[i];
            ack = 1'b1; m_pend = 1'b0;
            if (m_state == 3)
               for (int i = 0; i < NCH; i++) if (np[i]) m_F[i] = k + m_r[i];
            if (cfg_load) m_sh = lr;
         end else if (cfg_load) begin
            m_sh = lr; m_pend = 1'b1;
         end
         m_prev  = exttrig;
         m_state = ns;
         m_pulse = np;
         m_ack   = ack;
      end
   end

   // Compare DUT against the model every cycle, just after the active edge
   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         chk("model_state", 32'(state), 32'(m_state));
         chk("model_busy", 32'(busy), 32'(m_state != 0));
         chk("model_pulse", 32'(pulse_out), 32'(m_pulse));
         chk("model_ack", 32'(cfg_ack), 32'(m_ack));
         chk("model_pcnt", 32'(period_cnt), 32'(m_pcnt));
      end
   end

   // ---------------- directed stimulus ----------------
   function automatic logic [NCH*CNT_W-1:0] pack4(input int r0, input int r1,
                                                   input int r2, input int r3);
      return {16'(r3), 16'(r2), 16'(r1), 16'(r0)};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int r0, input int r1, input int r2, input int r3);
      div_ratio = pack4(r0, r1, r2, r3);
      cfg_load  = 1'b1;
      step(1);
      cfg_load  = 1'b0;
      step(1);
   endtask

   task automatic go();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (state !== 2'd0 && n < 200) begin
         step(1);
         n++;
      end
      chk(name, 32'(state), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] t1_exp [4];
      t1_exp = '{4'b0001, 4'b0010, 4'b0111, 4'b1100};

      reset = 1'b0; start = 1'b0; stop = 1'b0; exttrig = 1'b0; trig_mode = 1'b0;
      div_ratio = pack4(1, 1, 1, 1); cfg_load = 1'b0; burst_len = '0;
      step(2);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pulse", 32'(pulse_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pcnt", 32'(period_cnt), 32'd0);
      reset = 1'b1;
      step(1);

      // start and stop together: stop wins
      start = 1'b1; stop = 1'b1;
      step(1);
      start = 1'b0; stop = 1'b0;
      chk("start_stop_idle", 32'(state), 32'd0);

      // T1: ratios 1/2/3/4 continuous
      div_ratio = pack4(1, 2, 3, 4);
      cfg_load  = 1'b1;
      step(1);
      cfg_load  = 1'b0;
      chk("t1_ack", 32'(cfg_ack), 32'd1);
      step(1);
      chk("t1_ack_clear", 32'(cfg_ack), 32'd0);
      go();
      chk("t1_run", 32'(state), 32'd2);
      chk("t1_pulse_t0", 32'(pulse_out), 32'd0);
      for (int j = 0; j < 4; j++) begin
         step(1);
         chk("t1_pulse", 32'(pulse_out), 32'(t1_exp[j]));
      end
      step(20);
      stop = 1'b1; step(1); stop = 1'b0;
      wait_idle("t1_idle");

      // T2: burst of three master periods
      load(2, 3, 1, 4);
      burst_len = 16'd3;
      go();
      step(12);
      chk("t2_stop_state", 32'(state), 32'd3);
      chk("t2_pcnt", 32'(period_cnt), 32'd3);
      chk("t2_tail_pulse", 32'(pulse_out), 32'b1000);
      step(4);
      chk("t2_tail_done", 32'(pulse_out), 32'd0);
      chk("t2_still_stop", 32'(state), 32'd3);
      step(1);
      chk("t2_idle", 32'(state), 32'd0);
      burst_len = '0;

      // T3: arm on trigger
      trig_mode = 1'b1;
      go();
      chk("t3_armed", 32'(state), 32'd1);
      step(20);
      chk("t3_armed_hold", 32'(state), 32'd1);
      exttrig = 1'b1;
      step(1);
      chk("t3_trig_run", 32'(state), 32'd2);
      step(3);
      stop = 1'b1; step(1); stop = 1'b0;
      wait_idle("t3_idle");
      go();
      step(5);
      chk("t3_held_trig", 32'(state), 32'd1);
      exttrig = 1'b0;
      stop = 1'b1; step(1); stop = 1'b0;
      chk("t3_armed_stop", 32'(state), 32'd0);
      trig_mode = 1'b0;

      // T4: ratio change during RUN commits on the next master fall
      load(2, 2, 4, 4);
      go();
      step(5);
      div_ratio = pack4(5, 2, 4, 4);
      cfg_load  = 1'b1;
      step(1);
      cfg_load  = 1'b0;
      chk("t4_ack_wait", 32'(cfg_ack), 32'd0);
      step(2);
      chk("t4_ack", 32'(cfg_ack), 32'd1);
      chk("t4_realign", 32'(pulse_out), 32'd0);
      chk("t4_pcnt2", 32'(period_cnt), 32'd2);
      step(1);
      chk("t4_ack_clear", 32'(cfg_ack), 32'd0);
      step(3);
      chk("t4_ch0_low", 32'(pulse_out[0]), 32'd0);
      step(1);
      chk("t4_ch0_rise", 32'(pulse_out[0]), 32'd1);
      step(5);
      chk("t4_ch0_fall", 32'(pulse_out[0]), 32'd0);
      chk("t4_pcnt3", 32'(period_cnt), 32'd3);
      stop = 1'b1; step(1); stop = 1'b0;
      wait_idle("t4_idle");

      // T5: stop while ch3 is high completes its half-period
      load(1, 2, 3, 4);
      go();
      step(4);
      chk("t5_pre_stop", 32'(pulse_out), 32'b1100);
      stop = 1'b1; step(1); stop = 1'b0;
      chk("t5_stop_state", 32'(state), 32'd3);
      chk("t5_stop_pulse", 32'(pulse_out), 32'b1101);
      step(2);
      chk("t5_ch3_high", 32'(pulse_out), 32'b1000);
      step(1);
      chk("t5_all_low", 32'(pulse_out), 32'd0);
      step(1);
      chk("t5_idle", 32'(state), 32'd0);
      chk("t5_not_busy", 32'(busy), 32'd0);

      // T6: zero ratio clamps to 1; reset mid-run
      load(0, 0, 0, 0);
      go();
      step(1);
      chk("t6_clamp_high", 32'(pulse_out), 32'b1111);
      step(1);
      chk("t6_clamp_low", 32'(pulse_out), 32'd0);
      step(3);
      reset = 1'b0;
      step(1);
      chk("t6_rst_state", 32'(state), 32'd0);
      chk("t6_rst_pulse", 32'(pulse_out), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_pcnt", 32'(period_cnt), 32'd0);
      reset = 1'b1;
      go();
      step(3);
      chk("t6_post_rst_ratio1", 32'(pulse_out), 32'b1111);
      stop = 1'b1; step(1); stop = 1'b0;
      wait_idle("t6_idle");

      step(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
